// File: rtl/program_loader_if.sv
// Program byte stream, RAM write port and status signals of program_loader.
interface program_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, ram_we, ram_addr, ram_wdata,
    input  cpu_hold, busy, done, count, overflow
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, ram_we, ram_addr, ram_wdata,
    output cpu_hold, busy, done, count, overflow
  );
endinterface

// File: rtl/program_loader.sv
// Loads a program byte stream into a small RAM while holding the CPU in reset.
// Define LOADER_CLEAR_EN to zero the whole RAM before every load.
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic             clk,
  input logic             reset,
  program_loader_if.slave bus
);

`ifdef LOADER_CLEAR_EN
  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              booted_q;
  logic              hs;
  logic              last_slot;
  logic              in_fill;

  assign hs        = (state_q == LOAD) && bus.in_valid;
  // count never exceeds DEPTH-1 while in LOAD, so its low bits are the write pointer
  assign last_slot = &count_q[ADDR_W-1:0];

`ifdef LOADER_CLEAR_EN
  assign in_fill = (state_q == CLEAR) || (state_q == LOAD);
`else
  assign in_fill = (state_q == LOAD);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef LOADER_CLEAR_EN
          state_d = CLEAR;
`else
          state_d = LOAD;
`endif
        end
      end
`ifdef LOADER_CLEAR_EN
      CLEAR: begin
        if (&ram_addr_q) state_d = LOAD;
      end
`endif
      LOAD: begin
        if (hs && (bus.in_last || last_slot)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      booted_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ram_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef LOADER_CLEAR_EN
            ram_we_q    <= 1'b1;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
`endif
          end
        end
`ifdef LOADER_CLEAR_EN
        // ram_addr doubles as the clear sweep counter; the write registered
        // here is presented in the next CLEAR cycle
        CLEAR: begin
          if (!(&ram_addr_q)) begin
            ram_we_q   <= 1'b1;
            ram_addr_q <= ram_addr_q + 1'b1;
          end
        end
`endif
        LOAD: begin
          if (hs) begin
            ram_we_q    <= 1'b1;
            ram_addr_q  <= count_q[ADDR_W-1:0];
            ram_wdata_q <= bus.in_data;
            count_q     <= count_q + 1'b1;
            if (last_slot && !bus.in_last) overflow_q <= 1'b1;
          end
        end
        DONE:    booted_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  // held from reset until the first DONE, and again during every later fill
  assign bus.cpu_hold  = (state_q != DONE) && (!booted_q || in_fill);

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, RAM address width (DEPTH = 2**ADDR_W = 16 bytes).
REQ-002 SHALL have parameter DATA_W, default 8, RAM word width.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load sequence.
REQ-006 SHALL have port in_valid  input  1  upstream program byte valid.
REQ-007 SHALL have port in_data  input  DATA_W  program byte.
REQ-008 SHALL have port in_last  input  1  marks final byte of program.
REQ-009 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-010 SHALL have port ram_we  output  1  RAM write strobe.
REQ-011 SHALL have port ram_addr  output  ADDR_W  RAM write address.
REQ-012 SHALL have port ram_wdata  output  DATA_W  RAM write data.
REQ-013 SHALL have port cpu_hold  output  1  holds CPU in reset while high.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of sequence.
REQ-016 SHALL have port count  output  ADDR_W+1  bytes written in last load (0..DEPTH).
REQ-017 SHALL have port overflow  output  1  sticky: program exceeded DEPTH bytes.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, LOAD, DONE.
REQ-019 IDLE: start=1 -> CLEAR (clear compiled in) or LOAD (compiled out); counters and overflow zeroed at this transition.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 CLEAR: ram_we=1, ram_wdata=0, ram_addr 0..DEPTH-1 one address per cycle; after DEPTH-1 -> LOAD; in_ready=0.
REQ-022 LOAD: in_ready=1 combinationally; handshake = in_valid && in_ready.
REQ-023 On each handshake, next cycle SHALL present ram_we=1, ram_addr=write pointer, ram_wdata=in_data (registered, 1-cycle latency); pointer and count increment.
REQ-024 Handshake with in_last=1 SHALL write that byte then -> DONE.
REQ-025 Handshake at pointer DEPTH-1 with in_last=0 SHALL write that byte, set overflow=1, -> DONE; pointer never wraps to 0.
REQ-026 in_valid=0 in LOAD SHALL hold state, ram_we=0, no timeout.
REQ-027 DONE: done=1 for exactly one cycle, cpu_hold deasserts same cycle, in_ready=0, -> IDLE next cycle.
REQ-028 cpu_hold SHALL be 1 from reset until the first DONE, and 1 in CLEAR/LOAD of every later sequence; 0 otherwise.
REQ-029 count and overflow SHALL hold their values in IDLE until the next start.
REQ-030 ram_we SHALL be 0 whenever no write is scheduled; ram_addr/ram_wdata are don't-care then but stable.

Reset
REQ-031 reset=0 at a rising edge SHALL force IDLE, ram_we=0, ram_addr=0, ram_wdata=0, in_ready=0, busy=0, done=0, count=0, overflow=0, cpu_hold=1.
REQ-032 Reset mid-CLEAR or mid-LOAD SHALL abort with no further ram_we pulse after the reset edge; partially written RAM is left as is.

Configuration
REQ-033 Macro LOADER_CLEAR_EN defined: CLEAR state compiled in, every sequence zeroes all DEPTH bytes before LOAD (DEPTH extra cycles).
REQ-034 LOADER_CLEAR_EN undefined: CLEAR state and its logic absent; start goes IDLE -> LOAD; untouched RAM bytes retain prior contents.

Verification
REQ-035 Clear on; RAM pre-filled 8'hFF; start, 3 bytes 8'h1E,8'h2F,8'hF0 (last on 3rd) -> 16 zero writes, then addr 0..2 written, count=3, done pulse, overflow=0, RAM[3..15]=0.
REQ-036 Clear off; same stimulus -> no zero writes, RAM[3..15]=8'hFF, first ram_we one cycle after first handshake.
REQ-037 17 bytes, in_last never set -> 16 writes, overflow=1, count=16, in_ready=0 after 16th byte, 17th byte not written.
REQ-038 in_valid toggling 1,0,0,1,1(last) -> exactly 3 writes at addr 0,1,2, no ram_we on stall cycles.
REQ-039 reset=0 during LOAD after 2 bytes -> next cycle IDLE, cpu_hold=1, count=0, no further ram_we; RAM[0..1] retain loaded data.
REQ-040 start asserted during LOAD -> ignored; sequence completes once, single done pulse.
